// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage RV32I pipeline.
// Owns the PC, drives the synchronous instruction memory and presents
// {instr, pc, pc+4, valid} to decode. Honours stall, EX redirects and halt,
// traps misaligned redirect targets and keeps fetch performance counters.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   stall_i                    hazard-unit stall, hold the current fetch
//   redirect_i, redirect_pc_i  EX-resolved taken branch/jump and its target
//   halt_i                     level-sensitive fetch freeze
//   imem_addr_o                byte address to imem (combinational, = next PC)
//   imem_rdata_i               imem data, 1-cycle read of last imem_addr_o
//   if_instr_o/if_pc_o/if_pc_plus4_o/if_valid_o   slot presented to decode
//   misalign_o, err_pc_o       sticky misaligned-redirect error and target
//   fetch_cnt_o, stall_cnt_o, redirect_cnt_o      performance counters
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    input  logic             halt_i,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_rdata_i,
    output logic [31:0]      if_instr_o,
    output logic [31:0]      if_pc_o,
    output logic [31:0]      if_pc_plus4_o,
    output logic             if_valid_o,
    output logic             misalign_o,
    output logic [31:0]      err_pc_o,
    output logic [CNT_W-1:0] fetch_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_ERROR = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             valid_q, valid_d;
    logic             misalign_q, misalign_d;
    logic [31:0]      err_pc_q, err_pc_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

    logic [31:0]      next_pc;
    logic             redir_ok;
    logic             redir_bad;

    assign redir_ok  = redirect_i && (redirect_pc_i[1:0] == 2'b00);
    assign redir_bad = redirect_i && (redirect_pc_i[1:0] != 2'b00);

    // Slot to decode: squashed combinationally whenever a redirect is present.
    assign if_valid_o    = valid_q && (state_q == S_RUN) && !redirect_i;
    assign if_instr_o    = if_valid_o ? imem_rdata_i : NOP_INSTR;
    assign if_pc_o       = pc_q;
    assign if_pc_plus4_o = pc_q + 32'd4;
    assign imem_addr_o   = next_pc;

    assign misalign_o     = misalign_q;
    assign err_pc_o       = err_pc_q;
    assign fetch_cnt_o    = fetch_cnt_q;
    assign stall_cnt_o    = stall_cnt_q;
    assign redirect_cnt_o = redirect_cnt_q;

    // Next-state, next-PC and counter update.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        valid_d        = valid_q;
        misalign_d     = misalign_q;
        err_pc_d       = err_pc_q;
        fetch_cnt_d    = fetch_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        next_pc        = pc_q;

        unique case (state_q)
            S_BOOT: begin
                next_pc = RESET_PC;
                if (!halt_i) begin
                    state_d = S_RUN;
                    pc_d    = RESET_PC;
                    valid_d = 1'b1;
                end
            end

            S_RUN: begin
                if (redir_ok) begin
                    next_pc = redirect_pc_i;
                end else if (stall_i) begin
                    next_pc = pc_q;
                end else begin
                    next_pc = pc_q + 32'd4;
                end

                if (redir_bad) begin
                    // PC frozen; imem keeps re-reading the current address.
                    next_pc    = pc_q;
                    state_d    = S_ERROR;
                    misalign_d = 1'b1;
                    err_pc_d   = redirect_pc_i;
                    valid_d    = 1'b0;
                end else begin
                    pc_d = next_pc;
                    if (redir_ok) begin
                        redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
                    end
                    if (stall_i && !redirect_i) begin
                        stall_cnt_d = stall_cnt_q + CNT_W'(1);
                    end
                    if (if_valid_o && !stall_i) begin
                        fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
                    end
                    if (halt_i) begin
                        state_d = S_HALT;
                        valid_d = 1'b0;
                    end else begin
                        valid_d = 1'b1;
                    end
                end
            end

            S_HALT: begin
                // Re-read pc_q so its data is ready when fetch resumes.
                next_pc = redir_ok ? redirect_pc_i : pc_q;
                if (redir_bad) begin
                    state_d    = S_ERROR;
                    misalign_d = 1'b1;
                    err_pc_d   = redirect_pc_i;
                    valid_d    = 1'b0;
                end else begin
                    pc_d = next_pc;
                    if (redir_ok) begin
                        redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
                    end
                    if (!halt_i) begin
                        state_d = S_RUN;
                        valid_d = 1'b1;
                    end
                end
            end

            S_ERROR: begin
                next_pc = pc_q;
            end

            default: begin
                next_pc = pc_q;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_BOOT;
            pc_q           <= RESET_PC;
            valid_q        <= 1'b0;
            misalign_q     <= 1'b0;
            err_pc_q       <= 32'd0;
            fetch_cnt_q    <= '0;
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            valid_q        <= valid_d;
            misalign_q     <= misalign_d;
            err_pc_q       <= err_pc_d;
            fetch_cnt_q    <= fetch_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a vector table for the main fetch sequence plus
// hand-written sequences for reset pulse, redirect during halt, PC wrap and
// misaligned redirect from HALT. Memory model returns mem[a] = a | 0x1000.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, redirect_i, halt_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic [31:0] if_instr_o, if_pc_o, if_pc_plus4_o, err_pc_o;
    logic        if_valid_o, misalign_o;
    logic [31:0] fetch_cnt_o, stall_cnt_o, redirect_cnt_o;

    int n_total = 0;
    int n_pass  = 0;

    if_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .if_instr_o    (if_instr_o),
        .if_pc_o       (if_pc_o),
        .if_pc_plus4_o (if_pc_plus4_o),
        .if_valid_o    (if_valid_o),
        .misalign_o    (misalign_o),
        .err_pc_o      (err_pc_o),
        .fetch_cnt_o   (fetch_cnt_o),
        .stall_cnt_o   (stall_cnt_o),
        .redirect_cnt_o(redirect_cnt_o)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: one-cycle read.
    always @(posedge clk) imem_rdata_i <= imem_addr_o | 32'h0000_1000;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        halt;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_f;
        logic [31:0] e_s;
        logic [31:0] e_r;
        logic        e_mis;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rp,
                                input logic hl, input logic v, input logic [31:0] pc,
                                input logic [31:0] ins, input logic [31:0] f,
                                input logic [31:0] s, input logic [31:0] r, input logic m);
        vec_t x;
        x.stall = st; x.redir = rd; x.rpc = rp; x.halt = hl;
        x.e_valid = v; x.e_pc = pc; x.e_instr = ins;
        x.e_f = f; x.e_s = s; x.e_r = r; x.e_mis = m;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] rp, input logic hl);
        stall_i = st; redirect_i = rd; redirect_pc_i = rp; halt_i = hl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_slot(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] ins);
        chk({tag, ".valid"}, 32'(if_valid_o), 32'(v));
        chk({tag, ".pc"}, if_pc_o, pc);
        chk({tag, ".pc4"}, if_pc_plus4_o, pc + 32'd4);
        chk({tag, ".instr"}, if_instr_o, ins);
    endtask

    initial begin
        // Main sequence: rows checked one per cycle, counters are pre-edge values.
        vecs[0]  = mk(0, 0, 0,     0, 0, 32'h00, 32'h13,   0, 0, 0, 0); // BOOT
        vecs[1]  = mk(0, 0, 0,     0, 1, 32'h00, 32'h1000, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0,     0, 1, 32'h04, 32'h1004, 1, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0,     0, 1, 32'h08, 32'h1008, 2, 0, 0, 0);
        vecs[4]  = mk(1, 0, 0,     0, 1, 32'h08, 32'h1008, 2, 1, 0, 0);
        vecs[5]  = mk(1, 0, 0,     0, 1, 32'h08, 32'h1008, 2, 2, 0, 0);
        vecs[6]  = mk(0, 0, 0,     0, 1, 32'h08, 32'h1008, 2, 3, 0, 0);
        vecs[7]  = mk(0, 0, 0,     0, 1, 32'h0C, 32'h100C, 3, 3, 0, 0);
        vecs[8]  = mk(0, 1, 32'h40, 0, 0, 32'h10, 32'h13,  4, 3, 0, 0); // redirect squash
        vecs[9]  = mk(0, 0, 0,     0, 1, 32'h40, 32'h1040, 4, 3, 1, 0);
        vecs[10] = mk(1, 1, 32'h80, 0, 0, 32'h44, 32'h13,  5, 3, 1, 0); // redirect+stall
        vecs[11] = mk(0, 0, 0,     0, 1, 32'h80, 32'h1080, 5, 3, 2, 0);
        vecs[12] = mk(0, 0, 0,     1, 1, 32'h84, 32'h1084, 6, 3, 2, 0); // halt, 0x84 delivered
        vecs[13] = mk(0, 0, 0,     1, 0, 32'h88, 32'h13,   7, 3, 2, 0);
        vecs[14] = mk(0, 0, 0,     1, 0, 32'h88, 32'h13,   7, 3, 2, 0);
        vecs[15] = mk(0, 0, 0,     1, 0, 32'h88, 32'h13,   7, 3, 2, 0);
        vecs[16] = mk(0, 0, 0,     0, 0, 32'h88, 32'h13,   7, 3, 2, 0); // release
        vecs[17] = mk(0, 0, 0,     0, 1, 32'h88, 32'h1088, 7, 3, 2, 0);
        vecs[18] = mk(0, 1, 32'h102, 0, 0, 32'h8C, 32'h13, 8, 3, 2, 0); // misaligned
        vecs[19] = mk(0, 0, 0,     0, 0, 32'h8C, 32'h13,   8, 3, 2, 1);
        vecs[20] = mk(1, 1, 32'h200, 0, 0, 32'h8C, 32'h13, 8, 3, 2, 1);
        vecs[21] = mk(0, 0, 0,     0, 0, 32'h8C, 32'h13,   8, 3, 2, 1);

        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 32'(if_valid_o), 32'd0);
        chk("rst.instr", if_instr_o, 32'h13);
        chk("rst.addr", imem_addr_o, 32'h0);
        chk("rst.fetch", fetch_cnt_o, 32'd0);
        chk("rst.stall", stall_cnt_o, 32'd0);
        chk("rst.redir", redirect_cnt_o, 32'd0);
        chk("rst.mis", 32'(misalign_o), 32'd0);
        chk("rst.errpc", err_pc_o, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            drive(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].halt);
            chk_slot(tag, vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr);
            chk({tag, ".fetch"}, fetch_cnt_o, vecs[i].e_f);
            chk({tag, ".stall"}, stall_cnt_o, vecs[i].e_s);
            chk({tag, ".redir"}, redirect_cnt_o, vecs[i].e_r);
            chk({tag, ".mis"}, 32'(misalign_o), 32'(vecs[i].e_mis));
            tick();
        end
        chk("err.pc", err_pc_o, 32'h102);

        // Asynchronous reset mid-cycle clears everything immediately.
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        chk("arst.mis", 32'(misalign_o), 32'd0);
        chk("arst.errpc", err_pc_o, 32'd0);
        chk("arst.fetch", fetch_cnt_o, 32'd0);
        chk("arst.pc", if_pc_o, 32'h0);
        chk("arst.valid", 32'(if_valid_o), 32'd0);
        tick();
        rst_n = 1'b1;
        drive(0, 0, 0, 0);
        chk_slot("A", 0, 32'h0, 32'h13);                    // BOOT
        tick(); drive(0, 0, 0, 0);
        chk_slot("B", 1, 32'h0, 32'h1000);                  // restart at RESET_PC
        tick(); drive(0, 1, 32'h200, 1);
        chk_slot("C", 0, 32'h4, 32'h13);                    // redirect + halt
        tick(); drive(0, 1, 32'h300, 1);
        chk_slot("D", 0, 32'h200, 32'h13);                  // HALT at target
        chk("D.redir", redirect_cnt_o, 32'd1);
        tick(); drive(0, 0, 0, 0);
        chk_slot("E", 0, 32'h300, 32'h13);                  // redirect in HALT
        chk("E.redir", redirect_cnt_o, 32'd2);
        tick(); drive(0, 0, 0, 0);
        chk_slot("F", 1, 32'h300, 32'h1300);
        tick(); drive(0, 1, 32'hFFFF_FFFC, 0);
        chk_slot("G", 0, 32'h304, 32'h13);
        tick(); drive(0, 0, 0, 0);
        chk_slot("H", 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);      // pc+4 wraps
        tick(); drive(0, 0, 0, 1);
        chk_slot("I", 1, 32'h0, 32'h1000);
        chk("I.fetch", fetch_cnt_o, 32'd3);
        tick(); drive(0, 1, 32'h3, 1);
        chk_slot("J", 0, 32'h4, 32'h13);                    // misaligned from HALT
        tick(); drive(0, 0, 0, 0);
        chk("K.mis", 32'(misalign_o), 32'd1);
        chk("K.errpc", err_pc_o, 32'h3);
        chk("K.pc", if_pc_o, 32'h4);
        chk("K.fetch", fetch_cnt_o, 32'd4);
        chk("K.redir", redirect_cnt_o, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
